// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle instruction fetch front end.
// Issues credit-limited word fetches, buffers responses with their PCs, and flushes on redirect.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   imem_req_*        request channel (valid/addr registered, ready from memory)
//   imem_rsp_*        in-order responses, always accepted
//   inst_valid/ready  FIFO head handshake to the IDU; inst/inst_pc carry the head entry
//   redirect_*        single-cycle redirect from execute
//   halt              stops new requests (a pending request is kept)
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(4);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } req_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } entry_t;

  req_state_t      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   disc_q, disc_d;

  entry_t          fifo [DEPTH];
  entry_t          wr_entry;

  logic            acc;
  logic            drop;
  logic            push;
  logic            pop;
  logic            credit;
  logic [XLEN-1:0] target;
  logic            unused_bits;

  assign target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_bits = ^redirect_pc[1:0];

  assign acc  = (state_q == S_REQ) & imem_req_ready;
  assign drop = imem_rsp_valid & (disc_q != '0);
  assign push = imem_rsp_valid & ~drop;
  assign pop  = inst_valid & inst_ready;

  // Entries in the FIFO plus requests in flight must leave room
  // for every possible response.
  assign credit = ({1'b0, count_q} + {1'b0, out_q}) < LIMIT;

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = addr_q;
  assign inst_valid     = (count_q != '0);
  assign inst           = fifo[rd_q].data;
  assign inst_pc        = fifo[rd_q].pc;

  // Request channel: raise when idle with credit, hold until
  // accepted; a redirect withdraws.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (!redirect_valid && !halt && credit) begin
          state_d = S_REQ;
          addr_d  = fetch_pc_q;
        end
      end
      S_REQ: begin
        if (redirect_valid || imem_req_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    wr_d       = wr_q + PW'(push);
    rd_d       = rd_q + PW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    out_d      = out_q + CW'(acc) - CW'(imem_rsp_valid);
    disc_d     = disc_q - CW'(drop);

    if (acc) begin
      fetch_pc_d = fetch_pc_q + STEP;
    end

    // Live requests after a redirect are sequential from the
    // target, so a counter tracks the PC of the next kept response.
    if (push) begin
      rsp_pc_d = rsp_pc_q + STEP;
    end

    if (redirect_valid) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      wr_d       = '0;
      rd_d       = '0;
      count_d    = '0;
      disc_d     = out_d;
    end
  end

  always_comb begin
    wr_entry      = '0;
    wr_entry.pc   = rsp_pc_q;
    wr_entry.data = imem_rsp_data;
  end

  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      fifo[wr_q] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      out_q      <= '0;
      disc_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit against a
// queue-based model of the in-order memory and the IDU stream.
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b1;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN(32),
    .RESET_PC(RPC),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt(halt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // mem_q: addresses in flight at the memory (in order)
  // buf_q: PCs the IDU should see, oldest first
  logic [31:0] mem_q[$];
  logic [31:0] buf_q[$];
  int          discard;
  logic [31:0] mfetch;
  logic        exp_v;
  logic [31:0] exp_a;

  task automatic model_reset();
    mem_q.delete();
    buf_q.delete();
    discard = 0;
    mfetch  = RPC;
    exp_v   = 1'b0;
    exp_a   = RPC;
  endtask

  task automatic check_outs();
    chk("req_valid", 32'(imem_req_valid), 32'(exp_v));
    if (exp_v) chk("req_addr", imem_req_addr, exp_a);
    chk("inst_valid", 32'(inst_valid), 32'(buf_q.size() != 0));
    if (buf_q.size() != 0) begin
      chk("inst_pc", inst_pc, buf_q[0]);
      chk("inst", inst, mem_data(buf_q[0]));
    end
    chk("credit", 32'((buf_q.size() + mem_q.size()) <= DEPTH), 32'd1);
  endtask

  task automatic cycle(input int p_rdy, input int p_rsp,
                       input int p_ird, input int p_red,
                       input int p_hlt);
    logic        acc, rsp, pop, red, hlt, cred;
    logic [31:0] tgt, a;
    @(negedge clk);
    check_outs();
    imem_req_ready = ($urandom_range(99) < p_rdy);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_q.size() != 0 && $urandom_range(99) < p_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mem_q[0]);
    end
    inst_ready     = ($urandom_range(99) < p_ird);
    halt           = ($urandom_range(99) < p_hlt);
    redirect_valid = ($urandom_range(99) < p_red);
    case ($urandom_range(2))
      0:       redirect_pc = 32'h8000_0103;
      1:       redirect_pc = 32'hffff_fff6;
      default: redirect_pc = $urandom;
    endcase
    acc  = imem_req_valid & imem_req_ready;
    rsp  = imem_rsp_valid;
    pop  = inst_valid & inst_ready;
    red  = redirect_valid;
    hlt  = halt;
    cred = (buf_q.size() + mem_q.size()) < DEPTH;
    tgt  = {redirect_pc[31:2], 2'b00};
    if (acc) chk("acc_addr", imem_req_addr, mfetch);
    @(posedge clk);
    if (pop && buf_q.size() != 0) void'(buf_q.pop_front());
    if (rsp) begin
      assert (mem_q.size() > 0);
      a = mem_q.pop_front();
      if (discard > 0) discard--;
      else buf_q.push_back(a);
    end
    if (red || acc) exp_v = 1'b0;
    else if (!exp_v && !hlt && cred) begin
      exp_v = 1'b1;
      exp_a = mfetch;
    end
    if (acc) begin
      mem_q.push_back(mfetch);
      mfetch = mfetch + 32'd4;
    end
    if (red) begin
      buf_q.delete();
      discard = mem_q.size();
      mfetch  = tgt;
    end
  endtask

  task automatic do_reset();
    #2;
    rst            = 1'b0;
    halt           = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    #1;
    chk("arst_inst_valid", 32'(inst_valid), 32'd0);
    chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("arst_req_addr", imem_req_addr, RPC);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RPC);
    @(negedge clk);
    rst = 1'b1;

    repeat (30) cycle(100, 100, 100, 0, 0);

    repeat (16) cycle(100, 100, 0, 0, 0);
    cycle(100, 100, 100, 0, 0);
    repeat (10) cycle(100, 100, 0, 0, 0);

    repeat (2) cycle(100, 100, 100, 0, 0);
    repeat (3) cycle(0, 100, 100, 0, 100);
    repeat (10) cycle(100, 100, 100, 0, 100);

    repeat (400) cycle(70, 60, 60, 5, 5);
    repeat (400) cycle(40, 30, 30, 10, 10);

    repeat (6) cycle(100, 50, 0, 0, 0);
    do_reset();
    repeat (20) cycle(100, 100, 100, 0, 0);

    repeat (2000) cycle(60, 50, 70, 3, 5);

    repeat (8) cycle(100, 40, 50, 0, 0);
    do_reset();
    repeat (200) cycle(90, 90, 90, 2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
